// File: rtl/update_knn_pkg.sv
// Shared types and defaults for the update_knn datapath stages.
package update_knn_pkg;

  localparam int K_DEFAULT       = 3;
  localparam int DIST_W_DEFAULT  = 32;
  localparam int LABEL_W_DEFAULT = 4;
  localparam int CNT_W_DEFAULT   = 16;

  // Empty-slot marker; a sample at this distance can never displace anything.
  localparam logic [DIST_W_DEFAULT-1:0] DIST_MAX = '1;

  typedef enum logic {
    RUN = 1'b0,
    OUT = 1'b1
  } knn_state_t;

endpackage

// File: rtl/update_knn_topk_cmp.sv
// Parallel strict compare of a new distance against every list slot,
// returning the one-hot slot where the new entry belongs (zero if none).
module update_knn_topk_cmp #(
  parameter int K      = 3,
  parameter int DIST_W = 32
) (
  input  logic [K*DIST_W-1:0] list_dist,
  input  logic [DIST_W-1:0]   s_dist,
  output logic [K-1:0]        ins_onehot
);

  logic [K-1:0] lt;

  always_comb begin
    lt = '0;
    for (int i = 0; i < K; i++) begin
      lt[i] = s_dist < list_dist[i*DIST_W +: DIST_W];
    end
  end

  // Lowest set bit: strict compare means equal entries stay ahead of the new one.
  assign ins_onehot = lt & (~lt + K'(1));

endmodule

// File: rtl/update_knn_topk.sv
// Streaming top-K smallest-distance list with frame handshake toward the voter.
module update_knn_topk
  import update_knn_pkg::*;
#(
  parameter int K       = K_DEFAULT,
  parameter int DIST_W  = DIST_W_DEFAULT,
  parameter int LABEL_W = LABEL_W_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DIST_W-1:0]    s_dist,
  input  logic [LABEL_W-1:0]   s_label,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [K*DIST_W-1:0]  m_dist,
  output logic [K*LABEL_W-1:0] m_label,
  output logic [CNT_W-1:0]     m_count
);

  knn_state_t           state;
  logic [K*DIST_W-1:0]  dist_q;
  logic [K*DIST_W-1:0]  dist_d;
  logic [K*LABEL_W-1:0] label_q;
  logic [K*LABEL_W-1:0] label_d;
  logic [CNT_W-1:0]     count_q;
  logic [K-1:0]         ins_onehot;

  update_knn_topk_cmp #(
    .K      (K),
    .DIST_W (DIST_W)
  ) u_cmp (
    .list_dist  (dist_q),
    .s_dist     (s_dist),
    .ins_onehot (ins_onehot)
  );

  // Slots below the insert point hold, the insert slot takes the new sample,
  // slots above it take their lower neighbour; the top slot falls off.
  always_comb begin
    dist_d  = dist_q;
    label_d = label_q;
    if (ins_onehot[0]) begin
      dist_d[0 +: DIST_W]   = s_dist;
      label_d[0 +: LABEL_W] = s_label;
    end
    for (int i = 1; i < K; i++) begin
      if (ins_onehot[i]) begin
        dist_d[i*DIST_W +: DIST_W]    = s_dist;
        label_d[i*LABEL_W +: LABEL_W] = s_label;
      end else if ((ins_onehot & ((K'(1) << i) - K'(1))) != '0) begin
        dist_d[i*DIST_W +: DIST_W]    = dist_q[(i-1)*DIST_W +: DIST_W];
        label_d[i*LABEL_W +: LABEL_W] = label_q[(i-1)*LABEL_W +: LABEL_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      dist_q  <= '1;
      label_q <= '0;
      count_q <= '0;
    end else if (ce) begin
      case (state)
        RUN: begin
          if (s_valid) begin
            dist_q  <= dist_d;
            label_q <= label_d;
            if (count_q != '1) begin
              count_q <= count_q + CNT_W'(1);
            end
            if (s_last) begin
              state <= OUT;
            end
          end
        end
        OUT: begin
          if (m_ready) begin
            dist_q  <= '1;
            label_q <= '0;
            count_q <= '0;
            state   <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign s_ready = ce & (state == RUN);
  assign m_valid = (state == OUT);
  assign m_dist  = dist_q;
  assign m_label = label_q;
  assign m_count = count_q;

endmodule

// File: tb/tb_update_knn_topk.sv
// Directed self-checking bench for update_knn_topk (K=3, 32-bit distances).
module tb_update_knn_topk;

  localparam int K       = 3;
  localparam int DIST_W  = 32;
  localparam int LABEL_W = 4;
  localparam int CNT_W   = 16;
  localparam logic [95:0] ALL_EMPTY = '1;

  logic                 clk;
  logic                 reset;
  logic                 ce;
  logic                 s_valid;
  logic                 s_ready;
  logic [DIST_W-1:0]    s_dist;
  logic [LABEL_W-1:0]   s_label;
  logic                 s_last;
  logic                 m_valid;
  logic                 m_ready;
  logic [K*DIST_W-1:0]  m_dist;
  logic [K*LABEL_W-1:0] m_label;
  logic [CNT_W-1:0]     m_count;

  int n_checks;
  int n_fail;
  logic toggle_ce;

  update_knn_topk #(
    .K       (K),
    .DIST_W  (DIST_W),
    .LABEL_W (LABEL_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_dist  (s_dist),
    .s_label (s_label),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_dist  (m_dist),
    .m_label (m_label),
    .m_count (m_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Holds one sample on the bus until it is accepted; optionally flips ce each cycle.
  task automatic applyStimulus(input logic [31:0] d, input logic [3:0] l, input logic last);
    int   waited;
    logic acc;
    waited  = 0;
    acc     = 1'b0;
    s_valid = 1'b1;
    s_dist  = d;
    s_label = l;
    s_last  = last;
    while (!acc && waited < 20) begin
      if (toggle_ce) ce = ~ce;
      #1 acc = s_ready;
      @(negedge clk);
      waited++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!acc) checkOutput("accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic finishResult(input string tag);
    ce      = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checkOutput({tag, "_mvalid_clr"}, 128'(m_valid), 128'd0);
    checkOutput({tag, "_sready_up"}, 128'(s_ready), 128'd1);
    checkOutput({tag, "_dist_clr"}, 128'(m_dist), 128'(ALL_EMPTY));
    checkOutput({tag, "_count_clr"}, 128'(m_count), 128'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    toggle_ce = 1'b0;
    reset     = 1'b1;
    ce        = 1'b1;
    s_valid   = 1'b0;
    s_dist    = '0;
    s_label   = '0;
    s_last    = 1'b0;
    m_ready   = 1'b0;

    @(negedge clk);
    checkOutput("rst_dist", 128'(m_dist), 128'(ALL_EMPTY));
    checkOutput("rst_label", 128'(m_label), 128'd0);
    checkOutput("rst_count", 128'(m_count), 128'd0);
    checkOutput("rst_mvalid", 128'(m_valid), 128'd0);
    checkOutput("rst_sready", 128'(s_ready), 128'd1);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] basic sorted frame");
    applyStimulus(32'd50, 4'd1, 1'b0);
    applyStimulus(32'd20, 4'd2, 1'b0);
    applyStimulus(32'd70, 4'd3, 1'b0);
    checkOutput("basic_mvalid_pre", 128'(m_valid), 128'd0);
    applyStimulus(32'd10, 4'd4, 1'b1);
    checkOutput("basic_mvalid", 128'(m_valid), 128'd1);
    checkOutput("basic_dist", 128'(m_dist), 128'({32'd50, 32'd20, 32'd10}));
    checkOutput("basic_label", 128'(m_label), 128'({4'd1, 4'd2, 4'd4}));
    checkOutput("basic_count", 128'(m_count), 128'd4);
    finishResult("basic");

    $display("[TB] ties and backpressure");
    applyStimulus(32'd5, 4'd1, 1'b0);
    applyStimulus(32'd5, 4'd2, 1'b0);
    applyStimulus(32'd5, 4'd3, 1'b0);
    applyStimulus(32'd5, 4'd4, 1'b1);
    checkOutput("tie_dist", 128'(m_dist), 128'({32'd5, 32'd5, 32'd5}));
    checkOutput("tie_label", 128'(m_label), 128'({4'd3, 4'd2, 4'd1}));
    checkOutput("tie_count", 128'(m_count), 128'd4);
    s_valid = 1'b1;
    s_dist  = 32'd1;
    s_label = 4'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_sready", 128'(s_ready), 128'd0);
      checkOutput("bp_mvalid", 128'(m_valid), 128'd1);
      checkOutput("bp_label", 128'(m_label), 128'({4'd3, 4'd2, 4'd1}));
      checkOutput("bp_count", 128'(m_count), 128'd4);
    end
    s_valid = 1'b0;
    finishResult("bp");

    $display("[TB] short frames");
    applyStimulus(32'd7, 4'd3, 1'b1);
    checkOutput("short_dist", 128'(m_dist), 128'({32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7}));
    checkOutput("short_label", 128'(m_label), 128'({4'd0, 4'd0, 4'd3}));
    checkOutput("short_count", 128'(m_count), 128'd1);
    finishResult("short");
    applyStimulus(32'hFFFFFFFF, 4'd9, 1'b0);
    checkOutput("max_not_inserted", 128'(m_dist), 128'(ALL_EMPTY));
    checkOutput("max_label", 128'(m_label), 128'd0);
    checkOutput("max_counted", 128'(m_count), 128'd1);
    applyStimulus(32'd7, 4'd3, 1'b1);
    checkOutput("max_frame_dist", 128'(m_dist), 128'({32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7}));
    checkOutput("max_frame_count", 128'(m_count), 128'd2);
    finishResult("max");

    $display("[TB] ce toggling");
    toggle_ce = 1'b1;
    applyStimulus(32'd30, 4'd1, 1'b0);
    applyStimulus(32'd10, 4'd2, 1'b0);
    applyStimulus(32'd40, 4'd3, 1'b0);
    applyStimulus(32'd25, 4'd4, 1'b0);
    applyStimulus(32'd5, 4'd5, 1'b0);
    applyStimulus(32'd60, 4'd6, 1'b1);
    toggle_ce = 1'b0;
    checkOutput("ce_dist", 128'(m_dist), 128'({32'd25, 32'd10, 32'd5}));
    checkOutput("ce_label", 128'(m_label), 128'({4'd4, 4'd2, 4'd5}));
    checkOutput("ce_count", 128'(m_count), 128'd6);
    ce      = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("ce_hold_mvalid", 128'(m_valid), 128'd1);
    checkOutput("ce_hold_count", 128'(m_count), 128'd6);
    checkOutput("ce_hold_sready", 128'(s_ready), 128'd0);
    finishResult("ce");

    $display("[TB] reset mid-frame");
    applyStimulus(32'd1, 4'd1, 1'b0);
    applyStimulus(32'd2, 4'd2, 1'b0);
    applyStimulus(32'd3, 4'd3, 1'b0);
    checkOutput("mid_count_pre", 128'(m_count), 128'd3);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_dist", 128'(m_dist), 128'(ALL_EMPTY));
    checkOutput("mid_rst_label", 128'(m_label), 128'd0);
    checkOutput("mid_rst_count", 128'(m_count), 128'd0);
    checkOutput("mid_rst_mvalid", 128'(m_valid), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(32'd100, 4'd7, 1'b0);
    applyStimulus(32'd200, 4'd8, 1'b1);
    checkOutput("post_dist", 128'(m_dist), 128'({32'hFFFFFFFF, 32'd200, 32'd100}));
    checkOutput("post_label", 128'(m_label), 128'({4'd0, 4'd8, 4'd7}));
    checkOutput("post_count", 128'(m_count), 128'd2);
    finishResult("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/update_knn_topk.md
# update_knn_topk

Streaming K-nearest-neighbour insertion stage for the digit-recognition datapath. Sits directly downstream of the `update_knn` multiply/distance pipeline: it consumes one 32-bit unsigned distance per training sample (with its class label), maintains a sorted list of the K smallest distances seen in the current frame, and on frame end presents the list plus a sample count to the voting stage.

## Interface
- `K`, 3: list depth (1..8)
- `DIST_W`, 32: distance width (matches upstream product width)
- `LABEL_W`, 4: class label width
- `CNT_W`, 16: sample counter width
- `clk` in 1: clock, all state on rising edge
- `reset` in 1: asynchronous, active-high reset
- `ce` in 1: clock enable; when 0 the block holds all state
- `s_valid` in 1: input sample valid
- `s_ready` out 1: block accepts a sample this cycle
- `s_dist` in DIST_W: unsigned distance
- `s_label` in LABEL_W: label of sample
- `s_last` in 1: marks final sample of frame
- `m_valid` out 1: result list valid
- `m_ready` in 1: downstream accepts result
- `m_dist` out K*DIST_W: sorted distances, slot 0 (smallest) in LSBs
- `m_label` out K*LABEL_W: labels matching `m_dist` slots
- `m_count` out CNT_W: samples accepted in frame, saturating

## Operation
- Two states: RUN (collecting), OUT (presenting result).
- Accept = `ce & s_valid & s_ready`; `s_ready = ce & (state==RUN)`.
- On accept, single-cycle parallel insert: compare `s_dist` against every slot; position p = lowest i with `s_dist < dist[i]` (strict). Slots p..K-2 shift to p+1..K-1, slot K-1 dropped, new entry written at p. No slot strictly greater: list unchanged.
- Ties: existing entry keeps the lower slot (earlier sample wins).
- `m_count` increments on every accept, saturates at 2^CNT_W-1.
- Accept with `s_last=1`: insert as above, state -> OUT.
- In OUT: `m_valid=1`, outputs are the registered list; held stable until `ce & m_ready`. Then list cleared (all distances all-ones, labels 0), count cleared, state -> RUN.
- Empty slots hold distance all-ones / label 0; a sample with distance all-ones is never inserted.
- `ce=0`: no accept, no handshake completion, all registers hold; `m_valid` keeps its value.

## Timing
- Reset (async assert, applied immediately): state RUN, all `m_dist` slots all-ones, `m_label` 0, `m_count` 0, `m_valid` 0, `s_ready` = `ce`.
- Throughput: one sample per cycle in RUN.
- Latency: `m_valid` rises the cycle after the `s_last` accept; list includes the last sample.
- Result handshake completes in the cycle `m_valid & m_ready & ce`; `s_ready` rises the following cycle (one bubble per frame).
- `s_valid` while in OUT: not accepted, no state change.
- Reset mid-frame or during OUT: partial list discarded, returns to reset values.
- `s_last` on first sample of a frame: one-entry frame, `m_count`=1.

## Structure
- Shared package `update_knn_pkg`: `DIST_MAX` (all-ones), state enum {RUN, OUT}, default K/DIST_W/LABEL_W.
- One sub-module natural: `update_knn_topk_cmp` — combinational K-way strict compare producing the one-hot insert position; top level holds registers, shift logic, FSM.

## Test plan
- Reset, frame distances 50,20,70,10,s_last -> `m_dist` {10,20,50}, labels follow, `m_count`=4, `m_valid` one cycle after last.
- Ties: distances 5(L1),5(L2),5(L3),5(L4) -> slots labels {1,2,3}; L4 dropped.
- Backpressure: hold `m_ready`=0 for 10 cycles -> outputs stable, `s_ready`=0, `s_valid` samples ignored; `m_ready`=1 -> list cleared, `s_ready` next cycle.
- Short frame: single sample 7, s_last -> {7, FFFFFFFF, FFFFFFFF}, `m_count`=1; sample FFFFFFFF never inserted.
- `ce` toggling every other cycle during a 6-sample frame -> same result as `ce`=1 run, only accepts when `ce`=1.
- Assert `reset` mid-frame after 3 samples -> all outputs at reset values same cycle; next frame result unaffected by prior samples.
